// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Used by dmem_arbiter and arb_rr2.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam int P0  = 0;
    localparam int P1  = 1;
    localparam int LCW = 8;

endpackage

// File: rtl/arb_rr2.sv
// Two-way picker: a lone requester wins; on a tie the pointer decides,
// or port 0 wins outright when fixed priority is selected.
module arb_rr2
    import dmem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       ptr,
    input  logic       fixed,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            if (fixed || ptr == 1'b0) begin
                gnt[P0] = 1'b1;
            end else begin
                gnt[P1] = 1'b1;
            end
        end else begin
            gnt[P0] = req0;
            gnt[P1] = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one combinational-read data memory between the core (port 0) and a
// secondary master (port 1). Optional counters behind DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_LOCK   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          lock0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wd0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rd0,
    input  logic          req1,
    input  logic          lock1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rd1,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [31:0]   stat_gnt0,
    output logic [31:0]   stat_gnt1,
    output logic [31:0]   stat_conflict
`endif
);

    state_t         state_reg;
    logic           ptr_reg;
    logic [LCW-1:0] lock_cnt_reg;

    logic [1:0] pick;
    logic [1:0] gnt_vec;
    logic [1:0] we_vec;
    logic       win_port;
    logic       win_lock;
    logic       own_port;
    logic       own_req;
    logic       own_lock;
    logic       lock_done;

    arb_rr2 u_pick (
        .req0  (req0),
        .req1  (req1),
        .ptr   (ptr_reg),
        .fixed (FIXED_PRIO != 0),
        .gnt   (pick)
    );

    // Grants are gated by reset so every output reads 0 while it is held.
    always_comb begin
        gnt_vec = 2'b00;
        if (!reset) begin
            case (state_reg)
                OWN0:    gnt_vec[P0] = req0;
                OWN1:    gnt_vec[P1] = req1;
                default: gnt_vec = pick;
            endcase
        end
    end

    assign gnt0   = gnt_vec[P0];
    assign gnt1   = gnt_vec[P1];
    assign we_vec = {we1, we0};

    always_comb begin
        mem_we  = 1'b0;
        mem_adr = '0;
        mem_wd  = '0;
        if (gnt_vec[P0]) begin
            mem_we  = we0;
            mem_adr = adr0;
            mem_wd  = wd0;
        end else if (gnt_vec[P1]) begin
            mem_we  = we1;
            mem_adr = adr1;
            mem_wd  = wd1;
        end
    end

    assign win_port  = gnt_vec[P1];
    assign win_lock  = win_port ? lock1 : lock0;
    assign own_port  = (state_reg == OWN1);
    assign own_req   = own_port ? req1 : req0;
    assign own_lock  = own_port ? lock1 : lock0;
    assign lock_done = ({1'b0, lock_cnt_reg} + 9'd1) >= 9'(MAX_LOCK);

    // Ownership FSM: the lock counter tallies owner grants including the first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= 1'b0;
            lock_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt_vec != 2'b00) begin
                        if (win_lock && MAX_LOCK > 1) begin
                            state_reg    <= win_port ? OWN1 : OWN0;
                            lock_cnt_reg <= 8'd1;
                        end else begin
                            ptr_reg <= ~win_port;
                        end
                    end
                end
                OWN0, OWN1: begin
                    if (!own_req || !own_lock || lock_done) begin
                        state_reg    <= IDLE;
                        ptr_reg      <= ~own_port;
                        lock_cnt_reg <= '0;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    lock_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Per-port read-return registers: one-cycle rvalid pulse, rd held until the next read.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ret
            logic          rvalid_reg;
            logic [DW-1:0] rd_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rvalid_reg <= 1'b0;
                    rd_reg     <= '0;
                end else begin
                    rvalid_reg <= gnt_vec[gi] & ~we_vec[gi];
                    if (gnt_vec[gi] && !we_vec[gi]) begin
                        rd_reg <= mem_rd;
                    end
                end
            end
        end
    endgenerate

    assign rvalid0 = g_ret[0].rvalid_reg;
    assign rd0     = g_ret[0].rd_reg;
    assign rvalid1 = g_ret[1].rvalid_reg;
    assign rd1     = g_ret[1].rd_reg;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_gnt0_reg;
    logic [31:0] stat_gnt1_reg;
    logic [31:0] stat_conflict_reg;
    logic        conflict;

    assign conflict = (req0 & ~gnt_vec[P0]) | (req1 & ~gnt_vec[P1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_gnt0_reg     <= '0;
            stat_gnt1_reg     <= '0;
            stat_conflict_reg <= '0;
        end else if (stat_clr) begin
            stat_gnt0_reg     <= '0;
            stat_gnt1_reg     <= '0;
            stat_conflict_reg <= '0;
        end else begin
            if (gnt_vec[P0] && stat_gnt0_reg != 32'hFFFF_FFFF) begin
                stat_gnt0_reg <= stat_gnt0_reg + 32'd1;
            end
            if (gnt_vec[P1] && stat_gnt1_reg != 32'hFFFF_FFFF) begin
                stat_gnt1_reg <= stat_gnt1_reg + 32'd1;
            end
            if (conflict && stat_conflict_reg != 32'hFFFF_FFFF) begin
                stat_conflict_reg <= stat_conflict_reg + 32'd1;
            end
        end
    end

    assign stat_gnt0     = stat_gnt0_reg;
    assign stat_gnt1     = stat_gnt1_reg;
    assign stat_conflict = stat_conflict_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin instance driven from a vector table, plus a
// fixed-priority instance exercised by a short hand-written sequence.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Round-robin instance (a) with a small backing memory
    logic        req0_a, lock0_a, we0_a, req1_a, lock1_a, we1_a;
    logic [31:0] adr0_a, wd0_a, adr1_a, wd1_a;
    logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_we_a;
    logic [31:0] rd0_a, rd1_a, mem_adr_a, mem_wd_a, mem_rd_a;
    logic [31:0] mem [64];

    assign mem_rd_a = mem[mem_adr_a[7:2]];
    always @(posedge clk) begin
        if (mem_we_a) mem[mem_adr_a[7:2]] <= mem_wd_a;
    end

    // Fixed-priority instance (b): read data is a fixed function of address
    logic        req0_b, lock0_b, we0_b, req1_b, lock1_b, we1_b;
    logic [31:0] adr0_b, wd0_b, adr1_b, wd1_b;
    logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_we_b;
    logic [31:0] rd0_b, rd1_b, mem_adr_b, mem_wd_b, mem_rd_b;

    assign mem_rd_b = mem_adr_b ^ 32'hFFFF_0000;

`ifdef DMEM_ARB_STATS_EN
    logic        stat_clr_a = 1'b0;
    logic        stat_clr_b = 1'b0;
    logic [31:0] stat_gnt0_a, stat_gnt1_a, stat_conflict_a;
    logic [31:0] stat_gnt0_b, stat_gnt1_b, stat_conflict_b;
`endif

    dmem_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(0), .MAX_LOCK(8)) dut_a (
        .clk(clk), .reset(reset),
        .req0(req0_a), .lock0(lock0_a), .we0(we0_a), .adr0(adr0_a), .wd0(wd0_a),
        .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rd0(rd0_a),
        .req1(req1_a), .lock1(lock1_a), .we1(we1_a), .adr1(adr1_a), .wd1(wd1_a),
        .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rd1(rd1_a),
        .mem_we(mem_we_a), .mem_adr(mem_adr_a), .mem_wd(mem_wd_a), .mem_rd(mem_rd_a)
`ifdef DMEM_ARB_STATS_EN
        , .stat_clr(stat_clr_a), .stat_gnt0(stat_gnt0_a), .stat_gnt1(stat_gnt1_a),
        .stat_conflict(stat_conflict_a)
`endif
    );

    dmem_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1), .MAX_LOCK(8)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req0_b), .lock0(lock0_b), .we0(we0_b), .adr0(adr0_b), .wd0(wd0_b),
        .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rd0(rd0_b),
        .req1(req1_b), .lock1(lock1_b), .we1(we1_b), .adr1(adr1_b), .wd1(wd1_b),
        .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rd1(rd1_b),
        .mem_we(mem_we_b), .mem_adr(mem_adr_b), .mem_wd(mem_wd_b), .mem_rd(mem_rd_b)
`ifdef DMEM_ARB_STATS_EN
        , .stat_clr(stat_clr_b), .stat_gnt0(stat_gnt0_b), .stat_gnt1(stat_gnt1_b),
        .stat_conflict(stat_conflict_b)
`endif
    );

    typedef struct {
        logic        rst;
        logic        r0, l0, w0;
        logic [31:0] a0, d0;
        logic        r1, l1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, mwe;
        logic [31:0] madr, mwd;
        logic        rv0, rv1;
        logic [31:0] rd0, rd1;
    } vec_t;

    localparam int NV = 29;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic rst,
        input logic r0, input logic l0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic l1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
        input logic g0, input logic g1, input logic mwe, input logic [31:0] madr, input logic [31:0] mwd,
        input logic rv0, input logic rv1, input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.rst = rst;
        v.r0 = r0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.madr = madr; v.mwd = mwd;
        v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    localparam logic [31:0] B  = 32'hDEAD_BEEF;
    localparam logic [31:0] M2 = 32'h1000_0002;
    localparam logic [31:0] M3 = 32'h1000_0003;
    localparam logic [31:0] M4 = 32'h1000_0004;

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;

        // rst | port0 r l w adr wd | port1 r l w adr wd | g0 g1 mwe madr mwd | rv0 rv1 rd0 rd1
        tbl[0]  = mk(0, 0,0,0,32'h00,0, 0,0,0,32'h00,0,    0,0,0,32'h00,0, 0,0,0,0);
        tbl[1]  = mk(0, 1,0,1,32'h40,B, 0,0,0,32'h00,0,    1,0,1,32'h40,B, 0,0,0,0);
        tbl[2]  = mk(0, 1,0,0,32'h40,0, 0,0,0,32'h00,0,    1,0,0,32'h40,0, 0,0,0,0);
        tbl[3]  = mk(0, 0,0,0,32'h00,0, 0,0,0,32'h00,0,    0,0,0,32'h00,0, 1,0,B,0);
        tbl[4]  = mk(0, 0,0,0,32'h00,0, 0,0,0,32'h00,0,    0,0,0,32'h00,0, 0,0,B,0);
        tbl[5]  = mk(1, 0,0,0,32'h00,0, 0,0,0,32'h00,0,    0,0,0,32'h00,0, 0,0,0,0);
        tbl[6]  = mk(0, 1,0,0,32'h08,0, 1,0,0,32'h0C,0,    1,0,0,32'h08,0, 0,0,0,0);
        tbl[7]  = mk(0, 1,0,0,32'h08,0, 1,0,0,32'h0C,0,    0,1,0,32'h0C,0, 1,0,M2,0);
        tbl[8]  = mk(0, 1,0,0,32'h08,0, 1,0,0,32'h0C,0,    1,0,0,32'h08,0, 0,1,M2,M3);
        tbl[9]  = mk(0, 1,0,0,32'h08,0, 1,0,0,32'h0C,0,    0,1,0,32'h0C,0, 1,0,M2,M3);
        tbl[10] = mk(0, 0,0,0,32'h00,0, 0,0,0,32'h00,0,    0,0,0,32'h00,0, 0,1,M2,M3);
        tbl[11] = mk(0, 0,0,0,32'h00,0, 1,1,1,32'h80,32'h11, 0,1,1,32'h80,32'h11, 0,0,M2,M3);
        for (int k = 12; k <= 18; k++)
            tbl[k] = mk(0, 1,0,0,32'h08,0, 1,1,1,32'h80,32'h11, 0,1,1,32'h80,32'h11, 0,0,M2,M3);
        tbl[19] = mk(0, 1,0,0,32'h08,0, 1,1,1,32'h80,32'h11, 1,0,0,32'h08,0, 0,0,M2,M3);
        tbl[20] = mk(0, 0,0,0,32'h00,0, 1,1,1,32'h80,32'h11, 0,1,1,32'h80,32'h11, 1,0,M2,M3);
        tbl[21] = mk(0, 0,0,0,32'h00,0, 1,0,1,32'h80,32'h11, 0,1,1,32'h80,32'h11, 0,0,M2,M3);
        tbl[22] = mk(0, 0,0,0,32'h00,0, 0,0,0,32'h00,0,    0,0,0,32'h00,0, 0,0,M2,M3);
        tbl[23] = mk(0, 1,1,0,32'h10,0, 1,0,0,32'h0C,0,    1,0,0,32'h10,0, 0,0,M2,M3);
        tbl[24] = mk(0, 1,1,0,32'h10,0, 1,0,0,32'h0C,0,    1,0,0,32'h10,0, 1,0,M4,M3);
        tbl[25] = mk(1, 1,1,0,32'h10,0, 1,0,0,32'h0C,0,    0,0,0,32'h00,0, 0,0,0,0);
        tbl[26] = mk(0, 1,0,0,32'h10,0, 1,0,0,32'h0C,0,    1,0,0,32'h10,0, 0,0,0,0);
        tbl[27] = mk(0, 1,0,0,32'h10,0, 1,0,0,32'h0C,0,    0,1,0,32'h0C,0, 1,0,M4,0);
        tbl[28] = mk(0, 0,0,0,32'h00,0, 0,0,0,32'h00,0,    0,0,0,32'h00,0, 0,1,M4,M3);

        {req0_a, lock0_a, we0_a, adr0_a, wd0_a} = '0;
        {req1_a, lock1_a, we1_a, adr1_a, wd1_a} = '0;
        {req0_b, lock0_b, we0_b, adr0_b, wd0_b} = '0;
        {req1_b, lock1_b, we1_b, adr1_b, wd1_b} = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset   = tbl[i].rst;
            req0_a  = tbl[i].r0; lock0_a = tbl[i].l0; we0_a = tbl[i].w0;
            adr0_a  = tbl[i].a0; wd0_a   = tbl[i].d0;
            req1_a  = tbl[i].r1; lock1_a = tbl[i].l1; we1_a = tbl[i].w1;
            adr1_a  = tbl[i].a1; wd1_a   = tbl[i].d1;
            #1;
            $display("row %0d rst=%b gnt=%b%b mem_we=%b mem_adr=%h rvalid=%b%b rd0=%h rd1=%h",
                     i, reset, gnt0_a, gnt1_a, mem_we_a, mem_adr_a, rvalid0_a, rvalid1_a, rd0_a, rd1_a);
            chk($sformatf("row%0d gnt0", i),    {31'b0, gnt0_a},    {31'b0, tbl[i].g0});
            chk($sformatf("row%0d gnt1", i),    {31'b0, gnt1_a},    {31'b0, tbl[i].g1});
            chk($sformatf("row%0d mem_we", i),  {31'b0, mem_we_a},  {31'b0, tbl[i].mwe});
            chk($sformatf("row%0d mem_adr", i), mem_adr_a,          tbl[i].madr);
            chk($sformatf("row%0d mem_wd", i),  mem_wd_a,           tbl[i].mwd);
            chk($sformatf("row%0d rvalid0", i), {31'b0, rvalid0_a}, {31'b0, tbl[i].rv0});
            chk($sformatf("row%0d rvalid1", i), {31'b0, rvalid1_a}, {31'b0, tbl[i].rv1});
            chk($sformatf("row%0d rd0", i),     rd0_a,              tbl[i].rd0);
            chk($sformatf("row%0d rd1", i),     rd1_a,              tbl[i].rd1);
`ifdef DMEM_ARB_STATS_EN
            if (i == 10) begin
                chk("stat_gnt0 rr", stat_gnt0_a, 32'd2);
                chk("stat_gnt1 rr", stat_gnt1_a, 32'd2);
                chk("stat_conflict rr", stat_conflict_a, 32'd4);
            end
`endif
        end

        // Fixed priority: port 0 wins every tie, port 1 gets in once port 0 lets go.
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req0_b = (c < 4); adr0_b = 32'h04;
            req1_b = (c < 5); adr1_b = 32'h24;
            #1;
            $display("fixed cycle %0d gnt=%b%b rvalid=%b%b rd0=%h rd1=%h",
                     c, gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, rd0_b, rd1_b);
            chk($sformatf("fixed c%0d gnt0", c), {31'b0, gnt0_b}, (c < 4) ? 32'd1 : 32'd0);
            chk($sformatf("fixed c%0d gnt1", c), {31'b0, gnt1_b}, (c == 4) ? 32'd1 : 32'd0);
            if (c == 1) chk("fixed rd0", rd0_b, 32'hFFFF_0004);
            if (c == 5) begin
                chk("fixed rvalid1", {31'b0, rvalid1_b}, 32'd1);
                chk("fixed rd1", rd1_b, 32'hFFFF_0024);
            end
        end

`ifdef DMEM_ARB_STATS_EN
        @(negedge clk);
        chk("stat_gnt0 fixed", stat_gnt0_b, 32'd4);
        chk("stat_conflict fixed", stat_conflict_b, 32'd4);
        stat_clr_b = 1'b1;
        @(negedge clk);
        stat_clr_b = 1'b0;
        #1;
        chk("stat_gnt0 clr", stat_gnt0_b, 32'd0);
        chk("stat_gnt1 clr", stat_gnt1_b, 32'd0);
        chk("stat_conflict clr", stat_conflict_b, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
